// File: rtl/bgr_scan_pkg.sv
// ---------------------------------------------------------------------------
// bgr_scan_pkg
// Shared definitions for the bandgap array scan controller: the sequencer
// state encoding, the array size and the channel index width, plus a helper
// that advances a channel index with wrap-around.
//
// Optional feature macro used by the controller: BGR_SCAN_CONT_EN
// (continuous scanning instead of a single pass).
// ---------------------------------------------------------------------------
package bgr_scan_pkg;

    localparam int NCH  = 32;
    localparam int CH_W = 5;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_PORST,
        ST_SETTLE,
        ST_SELECT,
        ST_CONNECT,
        ST_SAMPLE,
        ST_BREAK,
        ST_NEXT,
        ST_DONE,
        ST_ABORT
    } state_t;

    // Channel indices are exactly CH_W bits wide, so 31 + 1 wraps to 0.
    function automatic logic [CH_W-1:0] next_chan(input logic [CH_W-1:0] c);
        return c + 1'b1;
    endfunction

endpackage

// File: rtl/bgr_scan_timer.sv
// ---------------------------------------------------------------------------
// bgr_scan_timer
// Loadable down-counter shared by every timed state of the scan sequencer.
// Loading value V makes 'expired' go high V cycles later, so a state that
// must last N cycles loads N-1 on the edge that enters it.
//
// Ports:
//   clk     - clock
//   rst     - asynchronous active-high reset
//   load    - load 'value' into the counter on this edge
//   value   - count to load
//   expired - counter has reached zero
// ---------------------------------------------------------------------------
module bgr_scan_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    output logic             expired
);

    logic [CNT_W-1:0] count;

    // Count down to zero and stop there; a load always wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/bgr_scan_ctrl.sv
// ---------------------------------------------------------------------------
// bgr_scan_ctrl
// Sequencer for the 32-macro bandgap array and its three 32:1 output muxes.
// For each channel of the requested range it pulses the macro's startup
// line, waits for settling, selects the channel with break-before-make,
// dwells, handshakes once with the external sampler and then opens the
// switch before moving on.
//
// Optional feature: define BGR_SCAN_CONT_EN to rescan the range
// continuously (done pulses per pass, only abort or rst end the scan).
//
// Ports:
//   clk, rst             - clock, asynchronous active-high reset
//   start                - one-cycle scan request (ignored while busy)
//   abort                - level, terminates the scan safely
//   ch_first, ch_last    - channel range, latched on an accepted start
//   sample_ack           - sampler captured the current outputs
//   porst[31:0]          - per-macro startup pulse
//   s_vbgr/s_va/s_vb     - mux selects (identical)
//   decoder_en_*         - decoder enables (identical)
//   switch_en_*          - switch enables (identical)
//   sample_req           - outputs stable, may be sampled
//   chan                 - channel being processed
//   busy, done, aborted  - scan status
// ---------------------------------------------------------------------------
module bgr_scan_ctrl
    import bgr_scan_pkg::*;
#(
    parameter int PORST_CYC  = 16,
    parameter int SETTLE_CYC = 256,
    parameter int GUARD_CYC  = 4,
    parameter int DWELL_CYC  = 64,
    parameter int CNT_W      = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic [CH_W-1:0] ch_first,
    input  logic [CH_W-1:0] ch_last,
    input  logic            sample_ack,
    output logic [NCH-1:0]  porst,
    output logic [CH_W-1:0] s_vbgr,
    output logic [CH_W-1:0] s_va,
    output logic [CH_W-1:0] s_vb,
    output logic            decoder_en_vbgr,
    output logic            decoder_en_va,
    output logic            decoder_en_vb,
    output logic            switch_en_vbgr,
    output logic            switch_en_va,
    output logic            switch_en_vb,
    output logic            sample_req,
    output logic [CH_W-1:0] chan,
    output logic            busy,
    output logic            done,
    output logic            aborted
);

    localparam logic [CNT_W-1:0] PORST_LD  = CNT_W'(PORST_CYC - 1);
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] GUARD_LD  = CNT_W'(GUARD_CYC - 1);
    localparam logic [CNT_W-1:0] DWELL_LD  = CNT_W'(DWELL_CYC - 1);

    state_t          state_q, state_d;
    logic [CH_W-1:0] chan_q, chan_d;
    logic [CH_W-1:0] last_q, last_d;
    logic            pend_q, pend_d;
`ifdef BGR_SCAN_CONT_EN
    logic [CH_W-1:0] first_q, first_d;
`endif

    logic             tmr_load;
    logic [CNT_W-1:0] tmr_value;
    logic             tmr_expired;

    logic [NCH-1:0]   porst_d, porst_q;
    logic [CH_W-1:0]  sel_d, sel_q;
    logic [CH_W-1:0]  chan_out_d, chan_out_q;
    logic             dec_d, dec_q;
    logic             sw_d, sw_q;
    logic             req_d, req_q;
    logic             busy_d, busy_q;
    logic             done_d, done_q;
    logic             aborted_d, aborted_q;

    bgr_scan_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (tmr_load),
        .value   (tmr_value),
        .expired (tmr_expired)
    );

    // State register plus the scan context: current channel, the latched
    // range end and a flag remembering that an abort arrived while the
    // switch was closed, so BREAK ends in ABORT instead of the next channel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            chan_q  <= '0;
            last_q  <= '0;
            pend_q  <= 1'b0;
`ifdef BGR_SCAN_CONT_EN
            first_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            chan_q  <= chan_d;
            last_q  <= last_d;
            pend_q  <= pend_d;
`ifdef BGR_SCAN_CONT_EN
            first_q <= first_d;
`endif
        end
    end

    // Next-state logic. Every timed state is entered together with a timer
    // load of its duration minus one. Abort leaves the unconnected states
    // directly, but once the switch is closed it always goes through BREAK
    // so the switch opens a guard time before the decoder is disabled.
    // Abort is tested before sample_ack so it wins a same-cycle collision.
    always_comb begin
        state_d   = state_q;
        chan_d    = chan_q;
        last_d    = last_q;
        pend_d    = pend_q;
        tmr_load  = 1'b0;
        tmr_value = '0;
`ifdef BGR_SCAN_CONT_EN
        first_d   = first_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    chan_d    = ch_first;
                    last_d    = ch_last;
                    pend_d    = 1'b0;
`ifdef BGR_SCAN_CONT_EN
                    first_d   = ch_first;
`endif
                    state_d   = ST_PORST;
                    tmr_load  = 1'b1;
                    tmr_value = PORST_LD;
                end
            end
            ST_PORST: begin
                if (abort) begin
                    state_d = ST_ABORT;
                end else if (tmr_expired) begin
                    state_d   = ST_SETTLE;
                    tmr_load  = 1'b1;
                    tmr_value = SETTLE_LD;
                end
            end
            ST_SETTLE: begin
                if (abort) begin
                    state_d = ST_ABORT;
                end else if (tmr_expired) begin
                    state_d   = ST_SELECT;
                    tmr_load  = 1'b1;
                    tmr_value = GUARD_LD;
                end
            end
            ST_SELECT: begin
                if (abort) begin
                    state_d = ST_ABORT;
                end else if (tmr_expired) begin
                    state_d   = ST_CONNECT;
                    tmr_load  = 1'b1;
                    tmr_value = DWELL_LD;
                end
            end
            ST_CONNECT: begin
                if (abort) begin
                    pend_d    = 1'b1;
                    state_d   = ST_BREAK;
                    tmr_load  = 1'b1;
                    tmr_value = GUARD_LD;
                end else if (tmr_expired) begin
                    state_d = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                if (abort || sample_ack) begin
                    pend_d    = abort;
                    state_d   = ST_BREAK;
                    tmr_load  = 1'b1;
                    tmr_value = GUARD_LD;
                end
            end
            ST_BREAK: begin
                if (abort) begin
                    pend_d = 1'b1;
                end
                if (tmr_expired) begin
                    if (pend_d) begin
                        state_d = ST_ABORT;
                    end else if (chan_q == last_q) begin
                        state_d = ST_DONE;
                    end else begin
                        chan_d  = next_chan(chan_q);
                        state_d = ST_NEXT;
                    end
                end
            end
            ST_NEXT: begin
                if (abort) begin
                    state_d = ST_ABORT;
                end else begin
                    state_d   = ST_PORST;
                    tmr_load  = 1'b1;
                    tmr_value = PORST_LD;
                end
            end
            ST_DONE: begin
`ifdef BGR_SCAN_CONT_EN
                if (abort) begin
                    state_d = ST_ABORT;
                end else begin
                    chan_d    = first_q;
                    state_d   = ST_PORST;
                    tmr_load  = 1'b1;
                    tmr_value = PORST_LD;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            ST_ABORT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state and channel, so the registered
    // outputs line up exactly with the state they describe. The select only
    // carries the channel while the decoder is enabled, which keeps it
    // constant for the whole enabled window.
    always_comb begin
        porst_d    = '0;
        sel_d      = '0;
        chan_out_d = '0;
        dec_d      = 1'b0;
        sw_d       = 1'b0;
        req_d      = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        aborted_d  = 1'b0;
        case (state_d)
            ST_PORST: begin
                porst_d    = {{(NCH-1){1'b0}}, 1'b1} << chan_d;
                chan_out_d = chan_d;
                busy_d     = 1'b1;
            end
            ST_SETTLE, ST_NEXT: begin
                chan_out_d = chan_d;
                busy_d     = 1'b1;
            end
            ST_SELECT, ST_BREAK: begin
                sel_d      = chan_d;
                dec_d      = 1'b1;
                chan_out_d = chan_d;
                busy_d     = 1'b1;
            end
            ST_CONNECT: begin
                sel_d      = chan_d;
                dec_d      = 1'b1;
                sw_d       = 1'b1;
                chan_out_d = chan_d;
                busy_d     = 1'b1;
            end
            ST_SAMPLE: begin
                sel_d      = chan_d;
                dec_d      = 1'b1;
                sw_d       = 1'b1;
                req_d      = 1'b1;
                chan_out_d = chan_d;
                busy_d     = 1'b1;
            end
            ST_DONE: begin
                done_d = 1'b1;
`ifdef BGR_SCAN_CONT_EN
                busy_d     = 1'b1;
                chan_out_d = chan_d;
`endif
            end
            ST_ABORT: begin
                aborted_d = 1'b1;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    // Output register; reset drives every output low asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            porst_q    <= '0;
            sel_q      <= '0;
            chan_out_q <= '0;
            dec_q      <= 1'b0;
            sw_q       <= 1'b0;
            req_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
        end else begin
            porst_q    <= porst_d;
            sel_q      <= sel_d;
            chan_out_q <= chan_out_d;
            dec_q      <= dec_d;
            sw_q       <= sw_d;
            req_q      <= req_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            aborted_q  <= aborted_d;
        end
    end

    assign porst           = porst_q;
    assign s_vbgr          = sel_q;
    assign s_va            = sel_q;
    assign s_vb            = sel_q;
    assign decoder_en_vbgr = dec_q;
    assign decoder_en_va   = dec_q;
    assign decoder_en_vb   = dec_q;
    assign switch_en_vbgr  = sw_q;
    assign switch_en_va    = sw_q;
    assign switch_en_vb    = sw_q;
    assign sample_req      = req_q;
    assign chan            = chan_out_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign aborted         = aborted_q;

endmodule

// File: tb/tb_bgr_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bgr_scan_ctrl
// Self-checking bench for bgr_scan_ctrl with default parameters
// (PORST 16, SETTLE 256, GUARD 4, DWELL 64). Per channel a scan takes
// 345 + W cycles, W being the number of sample_req cycles up to the ack.
// With BGR_SCAN_CONT_EN defined only the continuous-mode sequence runs.
// ---------------------------------------------------------------------------
module tb_bgr_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [4:0]  ch_first;
    logic [4:0]  ch_last;
    logic        sample_ack;
    logic [31:0] porst;
    logic [4:0]  s_vbgr, s_va, s_vb;
    logic        decoder_en_vbgr, decoder_en_va, decoder_en_vb;
    logic        switch_en_vbgr, switch_en_va, switch_en_vb;
    logic        sample_req;
    logic [4:0]  chan;
    logic        busy, done, aborted;

    wire [61:0] all_out = {porst, s_vbgr, s_va, s_vb,
                           decoder_en_vbgr, decoder_en_va, decoder_en_vb,
                           switch_en_vbgr, switch_en_va, switch_en_vb,
                           sample_req, chan, busy, done, aborted};

    bgr_scan_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .abort           (abort),
        .ch_first        (ch_first),
        .ch_last         (ch_last),
        .sample_ack      (sample_ack),
        .porst           (porst),
        .s_vbgr          (s_vbgr),
        .s_va            (s_va),
        .s_vb            (s_vb),
        .decoder_en_vbgr (decoder_en_vbgr),
        .decoder_en_va   (decoder_en_va),
        .decoder_en_vb   (decoder_en_vb),
        .switch_en_vbgr  (switch_en_vbgr),
        .switch_en_va    (switch_en_va),
        .switch_en_vb    (switch_en_vb),
        .sample_req      (sample_req),
        .chan            (chan),
        .busy            (busy),
        .done            (done),
        .aborted         (aborted)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    int check_count = 0;
    int pass_count  = 0;

    // Results recorded by applyStimulus, cycle 1 = first cycle after start.
    int t_porst_rise, porst_cnt, t_dec_rise, t_dec_fall, t_sw_rise, t_sw_fall;
    int t_req_rise, req_cycles, n_req, done_cnt, aborted_cnt, t_end;
    int s_at_dec, busy_at_1, busy_at_end;
    logic [31:0] porst_val;
    int chans[$];

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        check_count++;
        if (actual === expected) pass_count++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    // Structural invariants watched on every cycle outside reset.
    int         viol = 0;
    logic       prev_dec_m = 1'b0;
    logic [4:0] prev_s_m = '0;
    always @(negedge clk) begin
        if (rst) begin
            prev_dec_m = 1'b0;
        end else begin
            if (s_va != s_vbgr || s_vb != s_vbgr) viol++;
            if (decoder_en_va != decoder_en_vbgr || decoder_en_vb != decoder_en_vbgr) viol++;
            if (switch_en_va != switch_en_vbgr || switch_en_vb != switch_en_vbgr) viol++;
            if (switch_en_vbgr && !decoder_en_vbgr) viol++;
            if (porst != 32'h0 && porst != (32'h1 << chan)) viol++;
            if (prev_dec_m && decoder_en_vbgr && s_vbgr != prev_s_m) viol++;
            prev_dec_m = decoder_en_vbgr;
            prev_s_m   = s_vbgr;
        end
    end

    // Run one scan: pulse start, act as the sampler (ack on the ack_wait-th
    // sample_req cycle), optionally raise abort at a cycle or at a given
    // sample_req cycle, optionally re-pulse start mid-scan with another range.
    // Returns at the negedge of the cycle showing done or aborted.
    task automatic applyStimulus(input logic [4:0] first, input logic [4:0] last,
                                 input int ack_wait, input int abort_cyc,
                                 input int abort_req, input int busy_start_cyc,
                                 input int bound);
        int   cyc;
        int   req_run;
        logic p_dec, p_sw, p_req;
        t_porst_rise = -1; t_dec_rise = -1; t_dec_fall = -1; t_sw_rise = -1;
        t_sw_fall = -1; t_req_rise = -1; t_end = -1; porst_cnt = 0;
        req_cycles = 0; n_req = 0; done_cnt = 0; aborted_cnt = 0;
        s_at_dec = -1; busy_at_1 = -1; busy_at_end = -1; porst_val = '0;
        chans.delete();
        @(negedge clk);
        ch_first = first;
        ch_last  = last;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1; req_run = 0; p_dec = 1'b0; p_sw = 1'b0; p_req = 1'b0;
        while (1) begin
            if (cyc == 1) busy_at_1 = busy;
            if (porst != 0) begin
                porst_cnt++;
                if (t_porst_rise < 0) begin t_porst_rise = cyc; porst_val = porst; end
            end
            if (decoder_en_vbgr && !p_dec && t_dec_rise < 0) begin
                t_dec_rise = cyc; s_at_dec = s_vbgr;
            end
            if (!decoder_en_vbgr && p_dec && t_dec_fall < 0) t_dec_fall = cyc;
            if (switch_en_vbgr && !p_sw && t_sw_rise < 0) t_sw_rise = cyc;
            if (!switch_en_vbgr && p_sw && t_sw_fall < 0) t_sw_fall = cyc;
            if (sample_req) begin
                req_cycles++;
                if (!p_req) begin
                    n_req++;
                    chans.push_back(int'(chan));
                    if (t_req_rise < 0) t_req_rise = cyc;
                end
            end
            if (done) done_cnt++;
            if (aborted) aborted_cnt++;
            p_dec = decoder_en_vbgr; p_sw = switch_en_vbgr; p_req = sample_req;

            if (sample_req) req_run++; else req_run = 0;
            sample_ack = sample_req && (req_run == ack_wait);
            if ((abort_cyc > 0 && cyc == abort_cyc) ||
                (abort_req > 0 && sample_req && req_run == abort_req)) abort = 1'b1;
            if (busy_start_cyc > 0 && cyc == busy_start_cyc) begin
                start = 1'b1; ch_first = 5'd20; ch_last = 5'd25;
            end else begin
                start = 1'b0;
            end

            if (done || aborted) begin
                t_end = cyc; busy_at_end = busy;
                break;
            end
            if (cyc >= bound) begin
                check_count++;
                $display("[TB] FAIL scan_timeout: no done/aborted after %0d cycles, limit %0d", cyc, bound);
                break;
            end
            @(negedge clk);
            cyc++;
        end
        abort = 1'b0; sample_ack = 1'b0; start = 1'b0;
    endtask

    typedef struct {
        int first;
        int last;
        int ack_wait;
        int exp_nch;
        int exp_cycles;
    } vec_t;

    vec_t vecs[6];

    // Main sequence.
    initial begin
        int seen;
        rst = 1'b1; start = 1'b0; abort = 1'b0; sample_ack = 1'b0;
        ch_first = '0; ch_last = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_outputs", 64'(all_out), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("idle_outputs", 64'(all_out), 64'd0);

`ifdef BGR_SCAN_CONT_EN
        // Continuous: done after channel 1, then channel 0 restarts busy.
        applyStimulus(5'd0, 5'd1, 1, 0, 0, 0, 2000);
        checkOutput("cont_done_cycle", t_end, 692);
        checkOutput("cont_done_cnt", done_cnt, 1);
        checkOutput("cont_busy_at_done", busy_at_end, 1);
        checkOutput("cont_n_req", n_req, 2);
        @(negedge clk);
        checkOutput("cont_restart_porst", porst, 32'h1);
        checkOutput("cont_restart_busy", busy, 1);
        checkOutput("cont_restart_chan", chan, 0);
        abort = 1'b1;
        seen = 0;
        for (int i = 0; i < 10 && seen == 0; i++) begin
            @(negedge clk);
            if (aborted) seen = 1;
            if (done) seen = 2;
        end
        abort = 1'b0;
        checkOutput("cont_abort_ends_scan", seen, 1);
        @(negedge clk);
        checkOutput("cont_idle_after_abort", busy, 0);
`else
        // Single channel 3, ack on 5th request cycle: detailed timing.
        applyStimulus(5'd3, 5'd3, 5, 0, 0, 0, 1000);
        checkOutput("a_busy_first_cycle", busy_at_1, 1);
        checkOutput("a_porst_rise", t_porst_rise, 1);
        checkOutput("a_porst_value", porst_val, 32'h8);
        checkOutput("a_porst_len", porst_cnt, 16);
        checkOutput("a_dec_rise", t_dec_rise, 273);
        checkOutput("a_sel_at_dec", s_at_dec, 3);
        checkOutput("a_sw_after_dec", t_sw_rise - t_dec_rise, 4);
        checkOutput("a_req_after_sw", t_req_rise - t_sw_rise, 64);
        checkOutput("a_req_cycles", req_cycles, 5);
        checkOutput("a_done_after_sw_fall", t_end - t_sw_fall, 4);
        checkOutput("a_dec_fall_at_done", t_dec_fall, t_end);
        checkOutput("a_done_cycle", t_end, 350);
        checkOutput("a_busy_at_done", busy_at_end, 0);
        checkOutput("a_aborted", aborted_cnt, 0);

        // Range table.
        vecs[0] = '{first: 3,  last: 3,  ack_wait: 5, exp_nch: 1,  exp_cycles: 350};
        vecs[1] = '{first: 30, last: 1,  ack_wait: 1, exp_nch: 4,  exp_cycles: 1384};
        vecs[2] = '{first: 5,  last: 7,  ack_wait: 2, exp_nch: 3,  exp_cycles: 1041};
        vecs[3] = '{first: 31, last: 31, ack_wait: 1, exp_nch: 1,  exp_cycles: 346};
        vecs[4] = '{first: 4,  last: 3,  ack_wait: 1, exp_nch: 32, exp_cycles: 11072};
        vecs[5] = '{first: 0,  last: 31, ack_wait: 2, exp_nch: 32, exp_cycles: 11104};
        for (int i = 0; i < 6; i++) begin
            applyStimulus(5'(vecs[i].first), 5'(vecs[i].last), vecs[i].ack_wait,
                          0, 0, 0, 12000);
            checkOutput($sformatf("v%0d_end_cycle", i), t_end, vecs[i].exp_cycles);
            checkOutput($sformatf("v%0d_n_req", i), n_req, vecs[i].exp_nch);
            checkOutput($sformatf("v%0d_done", i), done_cnt, 1);
            checkOutput($sformatf("v%0d_aborted", i), aborted_cnt, 0);
            checkOutput($sformatf("v%0d_busy_end", i), busy_at_end, 0);
            for (int k = 0; k < chans.size(); k++)
                checkOutput($sformatf("v%0d_chan%0d", i, k), chans[k],
                            (vecs[i].first + k) % 32);
            repeat (2) @(negedge clk);
        end

        // Abort in SAMPLE on the same edge as sample_ack.
        applyStimulus(5'd3, 5'd3, 3, 0, 3, 0, 1000);
        checkOutput("ab_sw_fall", t_sw_fall, 344);
        checkOutput("ab_dec_after_sw", t_dec_fall - t_sw_fall, 4);
        checkOutput("ab_end_cycle", t_end, 348);
        checkOutput("ab_aborted", aborted_cnt, 1);
        checkOutput("ab_done", done_cnt, 0);
        checkOutput("ab_busy_end", busy_at_end, 0);
        repeat (2) @(negedge clk);

        // Abort in SETTLE: straight to the aborted pulse, decoder never on.
        applyStimulus(5'd9, 5'd12, 1, 100, 0, 0, 1000);
        checkOutput("as_end_cycle", t_end, 101);
        checkOutput("as_aborted", aborted_cnt, 1);
        checkOutput("as_done", done_cnt, 0);
        checkOutput("as_dec_never", t_dec_rise, -1);
        checkOutput("as_porst_len", porst_cnt, 16);
        repeat (2) @(negedge clk);

        // Start while busy is ignored; range stays 10..11.
        applyStimulus(5'd10, 5'd11, 2, 0, 0, 5, 2000);
        checkOutput("bs_end_cycle", t_end, 694);
        checkOutput("bs_n_req", n_req, 2);
        checkOutput("bs_chan0", chans.size() > 0 ? chans[0] : -1, 10);
        checkOutput("bs_chan1", chans.size() > 1 ? chans[1] : -1, 11);
        // Start in the done cycle is ignored too.
        start = 1'b1; ch_first = 5'd6; ch_last = 5'd6;
        @(negedge clk);
        start = 1'b0;
        checkOutput("ds_busy", busy, 0);
        checkOutput("ds_porst", porst, 0);
        repeat (2) @(negedge clk);

        // Reset mid-CONNECT clears outputs asynchronously.
        ch_first = 5'd7; ch_last = 5'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 0;
        for (int i = 0; i < 500 && seen == 0; i++) begin
            @(negedge clk);
            if (switch_en_vbgr) seen = 1;
        end
        checkOutput("rst_reached_connect", seen, 1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 checkOutput("rst_async_outputs", 64'(all_out), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(5'd2, 5'd2, 1, 0, 0, 0, 1000);
        checkOutput("rs_porst_rise", t_porst_rise, 1);
        checkOutput("rs_porst_value", porst_val, 32'h4);
        checkOutput("rs_end_cycle", t_end, 346);
        checkOutput("rs_n_req", n_req, 1);
        checkOutput("rs_done", done_cnt, 1);
`endif
        repeat (2) @(negedge clk);
        checkOutput("invariant_violations", viol, 0);
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

    // Global time bound.
    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "[TB] timeout");
    end

endmodule
